// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared types and default timing for the VGA raster timing generator.
//   rgb444_t    : RGB444 pixel as {r, g, b} nibbles
//   sync_bus_t  : {hsync, vsync, valid} bundle carried through the delay line
//   DEF_*       : 640x480@60 timing, 9x16 character cell, 2-cycle read latency
//   cnt_w()     : counter width able to hold 0..n-1
// ----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
    } sync_bus_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_CHAR_W   = 9;
    localparam int DEF_CHAR_H   = 16;
    localparam int DEF_LAT      = 2;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ----------------------------------------------------------------------------
// vga_delay_line
// LAT-stage register pipe that resets every stage to RST_VAL. Used to align
// the sync/valid bundle with the renderer's read latency.
//   pclk   in   1   pixel clock
//   rst_n  in   1   synchronous reset, active low
//   d      in   W   undelayed bundle
//   q      out  W   bundle delayed by LAT cycles (RST_VAL while flushed)
// With LAT=0 the pipe collapses to wires; the output is still forced to
// RST_VAL while rst_n is low so reset looks the same for every latency.
// ----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int             W       = 3,
    parameter int             LAT     = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (LAT == 0) begin : g_wire
            assign q = rst_n ? d : RST_VAL;
        end else begin : g_pipe
            logic [W-1:0] stage [LAT];

            // NOTE: this is a handful of flops, not a RAM, so every stage is
            // reset; a memory-style delay could not be flushed this way.
            always_ff @(posedge pclk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Counts x/y over the full raster,
// exports active-area pixel and character coordinates (stage 0), and delays
// hsync/vsync/valid by LAT cycles so they line up with renderer data that
// arrives LAT cycles after the coordinates. RGB is the renderer data gated by
// the delayed valid.
//   pclk        in   1   pixel clock
//   rst_n       in   1   synchronous reset, active low
//   vga_data    in   12  RGB444 from renderer, LAT cycles after h_addr/v_addr
//   h_addr      out  10  active-area x, 0 outside active (stage 0)
//   v_addr      out  10  active-area y, 0 outside active (stage 0)
//   h_char      out  7   character column (stage 0)
//   h_font      out  4   pixel within cell column (stage 0)
//   v_char      out  6   character row (stage 0)
//   v_font      out  4   line within cell row (stage 0)
//   frame_start out  1   one-cycle pulse at x=0,y=0 (stage 0)
//   hsync/vsync out  1   sync, delayed LAT cycles, level POL when asserted
//   valid       out  1   active-area flag, delayed LAT cycles
//   vga_r/g/b   out  4   vga_data gated by delayed valid
//   blink       out  1   bit 5 of a frame counter when VGA_BLINK_EN is
//                        defined, else tied 0
// Optional feature macro: VGA_BLINK_EN
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int CHAR_H   = DEF_CHAR_H,
    parameter int LAT      = DEF_LAT
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [11:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic [6:0]  h_char,
    output logic [3:0]  h_font,
    output logic [5:0]  v_char,
    output logic [3:0]  v_font,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        blink
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int XW      = cnt_w(H_TOTAL);
    localparam int YW      = cnt_w(V_TOTAL);

    localparam sync_bus_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, valid: 1'b0};

    logic [XW-1:0] x, x_next;
    logic [YW-1:0] y, y_next;
    logic          line_end;
    logic          h_act, h_act_next;
    logic          v_act, v_act_next;
    sync_bus_t     sync_raw, sync_dly;
    rgb444_t       pix;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        line_end   = (x == XW'(H_TOTAL - 1));
        x_next     = line_end ? '0 : x + XW'(1);
        y_next     = y;
        if (line_end) begin
            y_next = (y == YW'(V_TOTAL - 1)) ? '0 : y + YW'(1);
        end
        h_act      = (x >= XW'(H_START)) && (x < XW'(H_END));
        h_act_next = (x_next >= XW'(H_START)) && (x_next < XW'(H_END));
        v_act      = (y >= YW'(V_START)) && (y < YW'(V_END));
        v_act_next = (y_next >= YW'(V_START)) && (y_next < YW'(V_END));
    end

    // Raster and character counters. Cell counters step alongside x/y rather
    // than dividing h_addr/v_addr, and restart whenever the next position
    // leaves or enters the active span.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; reset is synchronous to pclk.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            h_char <= '0;
            h_font <= '0;
            v_char <= '0;
            v_font <= '0;
        end else begin
            x <= x_next;
            y <= y_next;

            if (h_act && h_act_next) begin
                if (h_font == 4'(CHAR_W - 1)) begin
                    h_font <= '0;
                    h_char <= h_char + 7'd1;
                end else begin
                    h_font <= h_font + 4'd1;
                end
            end else begin
                h_font <= '0;
                h_char <= '0;
            end

            if (line_end) begin
                if (v_act && v_act_next) begin
                    if (v_font == 4'(CHAR_H - 1)) begin
                        v_font <= '0;
                        v_char <= v_char + 6'd1;
                    end else begin
                        v_font <= v_font + 4'd1;
                    end
                end else begin
                    v_font <= '0;
                    v_char <= '0;
                end
            end
        end
    end

    always_comb begin
        h_addr = '0;
        v_addr = '0;
        if (h_act && v_act) begin
            h_addr = 10'(x - XW'(H_START));
            v_addr = 10'(y - YW'(V_START));
        end
    end

    // Gated by rst_n so the pulse is absent while reset is held and appears
    // in the first cycle after release, when the raster sits at 0,0.
    assign frame_start = rst_n && (x == '0) && (y == '0);

    always_comb begin
        sync_raw.hsync = (x < XW'(H_SYNC)) ? HS_POL : ~HS_POL;
        sync_raw.vsync = (y < YW'(V_SYNC)) ? VS_POL : ~VS_POL;
        sync_raw.valid = h_act && v_act;
    end

    vga_delay_line #(
        .W       ($bits(sync_bus_t)),
        .LAT     (LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_delay (
        .pclk  (pclk),
        .rst_n (rst_n),
        .d     (sync_raw),
        .q     (sync_dly)
    );

    assign hsync = sync_dly.hsync;
    assign vsync = sync_dly.vsync;
    assign valid = sync_dly.valid;

    assign pix   = vga_data;
    assign vga_r = pix.r & {4{sync_dly.valid}};
    assign vga_g = pix.g & {4{sync_dly.valid}};
    assign vga_b = pix.b & {4{sync_dly.valid}};

`ifdef VGA_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign blink = frame_cnt[5];
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. A shrunken raster keeps whole
// frames cheap. Instance A uses LAT=2 with active-low syncs; instance B uses
// LAT=0 with active-high syncs. The reference model derives every expected
// output from the number of cycles since reset release using plain
// arithmetic (modulo/divide) on the raster rules.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 20;
    localparam int H_FP     = 3;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 20;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int CHAR_W   = 9;
    localparam int CHAR_H   = 6;
    localparam int LAT_A    = 2;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 30
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 27
    localparam int FRAME    = H_TOTAL * V_TOTAL;                 // 810
    localparam int H_START  = H_SYNC + H_BP;                     // 7
    localparam int V_START  = V_SYNC + V_BP;                     // 5

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] vga_data = '0;

    logic [9:0]  h_addr_a, v_addr_a, h_addr_b, v_addr_b;
    logic [6:0]  h_char_a, h_char_b;
    logic [3:0]  h_font_a, h_font_b, v_font_a, v_font_b;
    logic [5:0]  v_char_a, v_char_b;
    logic        frame_start_a, frame_start_b;
    logic        hsync_a, vsync_a, valid_a, blink_a;
    logic        hsync_b, vsync_b, valid_b, blink_b;
    logic [3:0]  vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;

    int errors = 0;
    int checks = 0;
    int t_now  = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .LAT(LAT_A)
    ) u_dut_a (
        .pclk(pclk), .rst_n(rst_n), .vga_data(vga_data),
        .h_addr(h_addr_a), .v_addr(v_addr_a),
        .h_char(h_char_a), .h_font(h_font_a),
        .v_char(v_char_a), .v_font(v_font_a),
        .frame_start(frame_start_a),
        .hsync(hsync_a), .vsync(vsync_a), .valid(valid_a),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .blink(blink_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .LAT(0)
    ) u_dut_b (
        .pclk(pclk), .rst_n(rst_n), .vga_data(vga_data),
        .h_addr(h_addr_b), .v_addr(v_addr_b),
        .h_char(h_char_b), .h_font(h_font_b),
        .v_char(v_char_b), .v_font(v_font_b),
        .frame_start(frame_start_b),
        .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .blink(blink_b)
    );

    // ---------------- reference model ----------------
    // Stage-0 outputs for cycle t after release:
    // {h_addr, v_addr, h_char, h_font, v_char, v_font, frame_start}
    function automatic logic [41:0] exp_stage0(input int t);
        int x, y, hx, vy;
        bit ha, va;
        x  = t % H_TOTAL;
        y  = (t / H_TOTAL) % V_TOTAL;
        hx = x - H_START;
        vy = y - V_START;
        ha = (x >= H_START) && (x < H_START + H_ACTIVE);
        va = (y >= V_START) && (y < V_START + V_ACTIVE);
        return {10'((ha && va) ? hx : 0), 10'((ha && va) ? vy : 0),
                7'(ha ? hx / CHAR_W : 0), 4'(ha ? hx % CHAR_W : 0),
                6'(va ? vy / CHAR_H : 0), 4'(va ? vy % CHAR_H : 0),
                1'((x == 0) && (y == 0))};
    endfunction

    // Delayed outputs {hsync, vsync, valid, r, g, b} for cycle t.
    function automatic logic [14:0] exp_pipe(input int t, input int lat,
                                             input bit hpol, input bit vpol,
                                             input logic [11:0] d);
        int x, y;
        bit hs, vs, va;
        if (t < lat) begin
            hs = ~hpol;
            vs = ~vpol;
            va = 1'b0;
        end else begin
            x  = (t - lat) % H_TOTAL;
            y  = ((t - lat) / H_TOTAL) % V_TOTAL;
            hs = (x < H_SYNC) ? hpol : ~hpol;
            vs = (y < V_SYNC) ? vpol : ~vpol;
            va = (x >= H_START) && (x < H_START + H_ACTIVE) &&
                 (y >= V_START) && (y < V_START + V_ACTIVE);
        end
        return {hs, vs, va, d & {12{va}}};
    endfunction

    // Blink phase: frames started strictly before cycle t, bit 5.
    function automatic bit exp_blink(input int t);
`ifdef VGA_BLINK_EN
        int n;
        n = (t == 0) ? 0 : ((t - 1) / FRAME + 1);
        return ((n / 32) % 2) == 1;
`else
        return (t < 0);
`endif
    endfunction

    // Advance one cycle: new renderer data just after the edge, settle.
    task automatic step();
        @(posedge pclk);
        #1;
        vga_data = 12'($urandom);
        t_now++;
        #2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [14:0] obs;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            obs = {hsync_a, vsync_a, valid_a, vga_r_a, vga_g_a, vga_b_a};
            checks++;
            if (obs !== {3'b110, 12'h000}) begin
                errors++;
                $display("FAIL reset_pipe_a cyc=%0d got=%h exp=%h", i, obs, {3'b110, 12'h000});
            end
            obs = {hsync_b, vsync_b, valid_b, vga_r_b, vga_g_b, vga_b_b};
            checks++;
            if (obs !== 15'h0) begin
                errors++;
                $display("FAIL reset_pipe_b cyc=%0d got=%h exp=0", i, obs);
            end
            checks++;
            if ({h_addr_a, v_addr_a, frame_start_a, blink_a} !== 22'h0) begin
                errors++;
                $display("FAIL reset_stage0 cyc=%0d h_addr=%0d v_addr=%0d fs=%b blink=%b exp all 0",
                         i, h_addr_a, v_addr_a, frame_start_a, blink_a);
            end
        end
        rst_n = 1'b1;
        t_now = 0;
        #1;
        checks++;
        if (frame_start_a !== 1'b1 || frame_start_b !== 1'b1) begin
            errors++;
            $display("FAIL release_frame_start got a=%b b=%b exp 1", frame_start_a, frame_start_b);
        end
    endtask

    task automatic test_free_run();
        int hs_low = 0;
        int vs_low = 0;
        int first_valid = -1;
        logic [41:0] e0;
        logic [14:0] pa, pb;
        while (t_now < 2 * FRAME + 40) begin
            step();
            e0 = exp_stage0(t_now);
            pa = exp_pipe(t_now, LAT_A, 1'b0, 1'b0, vga_data);
            pb = exp_pipe(t_now, 0, 1'b1, 1'b1, vga_data);
            checks++;
            if ({h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a, frame_start_a} !== e0) begin
                errors++;
                $display("FAIL stage0 t=%0d got=%h exp=%h", t_now,
                         {h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a, frame_start_a}, e0);
            end
            checks++;
            if ({hsync_a, vsync_a, valid_a, vga_r_a, vga_g_a, vga_b_a} !== pa) begin
                errors++;
                $display("FAIL pipe_a t=%0d got=%h exp=%h", t_now,
                         {hsync_a, vsync_a, valid_a, vga_r_a, vga_g_a, vga_b_a}, pa);
            end
            checks++;
            if ({hsync_b, vsync_b, valid_b, vga_r_b, vga_g_b, vga_b_b} !== pb) begin
                errors++;
                $display("FAIL pipe_b t=%0d got=%h exp=%h", t_now,
                         {hsync_b, vsync_b, valid_b, vga_r_b, vga_g_b, vga_b_b}, pb);
            end
            checks++;
            if (blink_a !== exp_blink(t_now)) begin
                errors++;
                $display("FAIL blink t=%0d got=%b exp=%b", t_now, blink_a, exp_blink(t_now));
            end
            if (t_now >= LAT_A && t_now < LAT_A + FRAME) begin
                if (hsync_a === 1'b0) hs_low++;
                if (vsync_a === 1'b0) vs_low++;
            end
            if (first_valid < 0 && valid_a === 1'b1) first_valid = t_now;
        end
        checks++;
        if (hs_low != H_SYNC * V_TOTAL) begin
            errors++;
            $display("FAIL hsync_low_count got=%0d exp=%0d", hs_low, H_SYNC * V_TOTAL);
        end
        checks++;
        if (vs_low != V_SYNC * H_TOTAL) begin
            errors++;
            $display("FAIL vsync_low_count got=%0d exp=%0d", vs_low, V_SYNC * H_TOTAL);
        end
        checks++;
        if (first_valid != V_START * H_TOTAL + H_START + LAT_A) begin
            errors++;
            $display("FAIL first_valid got=%0d exp=%0d", first_valid, V_START * H_TOTAL + H_START + LAT_A);
        end
    endtask

    // Last active pixel: h_addr=19 -> cell 2 pixel 1; v_addr=19 -> row 3 line 1.
    task automatic test_char_bounds();
        int target;
        target = (V_START + V_ACTIVE - 1) * H_TOTAL + (H_START + H_ACTIVE - 1);
        for (int i = 0; i < FRAME && (t_now % FRAME) != target; i++) step();
        checks++;
        if ({h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a} !==
            {10'd19, 10'd19, 7'd2, 4'd1, 6'd3, 4'd1}) begin
            errors++;
            $display("FAIL char_last t=%0d got ha=%0d va=%0d hc=%0d hf=%0d vc=%0d vf=%0d exp 19 19 2 1 3 1",
                     t_now, h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a);
        end
        step();
        checks++;
        if ({h_addr_a, h_char_a, h_font_a} !== 21'h0) begin
            errors++;
            $display("FAIL char_clear t=%0d got ha=%0d hc=%0d hf=%0d exp 0", t_now, h_addr_a, h_char_a, h_font_a);
        end
    endtask

    task automatic test_mid_reset();
        logic [14:0] pa;
        for (int i = 0; i < FRAME && !((t_now % H_TOTAL) == 15 && ((t_now / H_TOTAL) % V_TOTAL) == 10); i++) step();
        checks++;
        if (h_addr_a !== 10'd8 || v_addr_a !== 10'd5) begin
            errors++;
            $display("FAIL pre_reset_pos got ha=%0d va=%0d exp 8 5", h_addr_a, v_addr_a);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        t_now = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            pa = exp_pipe(t_now, LAT_A, 1'b0, 1'b0, vga_data);
            checks++;
            if ({h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a, frame_start_a} !== exp_stage0(t_now)) begin
                errors++;
                $display("FAIL restart_stage0 t=%0d got=%h exp=%h", t_now,
                         {h_addr_a, v_addr_a, h_char_a, h_font_a, v_char_a, v_font_a, frame_start_a}, exp_stage0(t_now));
            end
            checks++;
            if ({hsync_a, vsync_a, valid_a, vga_r_a, vga_g_a, vga_b_a} !== pa) begin
                errors++;
                $display("FAIL restart_pipe_a t=%0d got=%h exp=%h", t_now,
                         {hsync_a, vsync_a, valid_a, vga_r_a, vga_g_a, vga_b_a}, pa);
            end
        end
    endtask

    task automatic test_blink();
`ifdef VGA_BLINK_EN
        int limit = 64 * FRAME + 4;
`else
        int limit = t_now + 200;
`endif
        int toggles = 0;
        logic prev = blink_a;
        while (t_now < limit) begin
            step();
            if (blink_a !== prev) toggles++;
            prev = blink_a;
            checks++;
            if (blink_a !== exp_blink(t_now)) begin
                errors++;
                $display("FAIL blink_run t=%0d got=%b exp=%b", t_now, blink_a, exp_blink(t_now));
            end
        end
        checks++;
`ifdef VGA_BLINK_EN
        if (toggles != 2) begin
`else
        if (toggles != 0) begin
`endif
            errors++;
            $display("FAIL blink_toggles got=%0d", toggles);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_char_bounds();
        test_mid_reset();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
